// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Widths are passed in so one package serves every format.
package fp_mul_pkg;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_W         = 4;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // {0, all-ones exponent, quiet bit set, rest zero}
    function automatic logic [63:0] fp_qnan(input int exp_w,
                                            input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

    // subnormals land in CLS_ZERO (flush-to-zero)
    function automatic fp_class_e fp_classify(input logic [63:0] e,
                                              input logic [63:0] f,
                                              input int exp_w);
        logic [63:0] ones;
        ones = (64'd1 << exp_w) - 64'd1;
        if (e == ones) begin
            return (|f) ? CLS_NAN : CLS_INF;
        end
        if (e == 64'd0) begin
            return CLS_ZERO;
        end
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and IEEE packing of a normalised product.
// Purely combinational; shared with future adder/FMA datapaths.
module fp_round_pack
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [2*MAN_W+1:0]   prod,
    input  logic [EXP_W+1:0]     exp_in,
    input  logic                 sign,
    input  fp_class_e            cls,
    input  logic                 invalid,
    output logic [EXP_W+MAN_W:0] res,
    output logic [FLAG_W-1:0]    flags
);

    localparam logic [63:0] QNAN_64 = fp_qnan(EXP_W, MAN_W);
    localparam logic [EXP_W+MAN_W:0] QNAN = QNAN_64[EXP_W+MAN_W:0];
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    logic [MAN_W-1:0] frac;
    logic [MAN_W-1:0] frac_r;
    logic             lsb;
    logic             guard;
    logic             sticky;
    logic             rnd_up;
    logic             carry;
    logic [EXP_W+1:0] exp_r;
    logic             ovf;
    logic             unf;

    // RNE on the bits below the kept fraction; carry-out wraps frac to 0
    always_comb begin
        frac   = prod[2*MAN_W:MAN_W+1];
        lsb    = prod[MAN_W+1];
        guard  = prod[MAN_W];
        sticky = |prod[MAN_W-1:0];
        rnd_up = guard & (sticky | lsb);
        {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
        exp_r  = exp_in + {{(EXP_W+1){1'b0}}, carry};
        ovf    = !exp_r[EXP_W+1] &&
                 (exp_r[EXP_W:0] >= {1'b0, EXP_ONES});
        unf    = exp_r[EXP_W+1] || (exp_r == '0);
    end

    // choose special, saturated or rounded encoding
    always_comb begin
        res   = '0;
        flags = '0;
        unique case (cls)
            CLS_NAN: begin
                res = QNAN;
                flags[FLAG_INVALID] = invalid;
            end
            CLS_INF: begin
                res = {sign, EXP_ONES, {MAN_W{1'b0}}};
            end
            CLS_ZERO: begin
                res = {sign, {(EXP_W+MAN_W){1'b0}}};
            end
            CLS_NORM: begin
                if (ovf) begin
                    res = {sign, EXP_ONES, {MAN_W{1'b0}}};
                    flags[FLAG_OVERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]  = 1'b1;
                end else if (unf) begin
                    res = {sign, {(EXP_W+MAN_W){1'b0}}};
                    flags[FLAG_UNDERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]   = 1'b1;
                end else begin
                    res = {sign, exp_r[EXP_W-1:0], frac_r};
                    flags[FLAG_INEXACT] = guard | sticky;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier with operand truncation and a
// single global stall driven by the output handshake.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TW    = $clog2(MAN_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [TW-1:0]        trunc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] res,
    output logic [FLAG_W-1:0]    flags
);

    localparam int SIG_W = MAN_W + 1;
    localparam int PRD_W = 2 * MAN_W + 2;
    localparam logic [63:0] BIAS_64 = 64'(fp_bias(EXP_W));
    localparam logic [EXP_W+1:0] BIAS_X = BIAS_64[EXP_W+1:0];

    logic advance;

    // stage 1 combinational
    logic [TW-1:0]      kc;
    logic [MAN_W:0]     ones_lo;
    logic [MAN_W-1:0]   mask;
    logic [MAN_W-1:0]   fa;
    logic [MAN_W-1:0]   fb;
    logic [EXP_W-1:0]   ea;
    logic [EXP_W-1:0]   eb;
    fp_class_e          ca;
    fp_class_e          cb;
    fp_class_e          cls_c;
    logic               inv_c;
    logic [EXP_W+1:0]   esum_c;

    // stage 1 registers
    logic               s1_valid;
    logic               s1_sign;
    fp_class_e          s1_cls;
    logic               s1_inv;
    logic [EXP_W+1:0]   s1_exp;
    logic [SIG_W-1:0]   s1_ma;
    logic [SIG_W-1:0]   s1_mb;

    // stage 2
    logic [PRD_W-1:0]   prod_c;
    logic               s2_valid;
    logic               s2_sign;
    fp_class_e          s2_cls;
    logic               s2_inv;
    logic [EXP_W+1:0]   s2_exp;
    logic [PRD_W-1:0]   s2_prod;

    // stage 3
    logic               norm;
    logic [PRD_W-1:0]   nprod;
    logic [EXP_W+1:0]   nexp;
    logic [EXP_W+MAN_W:0] rp_res;
    logic [FLAG_W-1:0]  rp_flags;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // truncate operands, classify, sum exponents
    always_comb begin
        kc = (int'(trunc) > MAN_W) ? TW'(MAN_W) : trunc;
        ones_lo = ({{MAN_W{1'b0}}, 1'b1} << kc) -
                  {{MAN_W{1'b0}}, 1'b1};
        mask = ~ones_lo[MAN_W-1:0];
        fa = a[MAN_W-1:0] & mask;
        fb = b[MAN_W-1:0] & mask;
        ea = a[EXP_W+MAN_W-1:MAN_W];
        eb = b[EXP_W+MAN_W-1:MAN_W];
        ca = fp_classify({{(64-EXP_W){1'b0}}, ea},
                         {{(64-MAN_W){1'b0}}, fa}, EXP_W);
        cb = fp_classify({{(64-EXP_W){1'b0}}, eb},
                         {{(64-MAN_W){1'b0}}, fb}, EXP_W);
        inv_c = (ca == CLS_INF && cb == CLS_ZERO) ||
                (ca == CLS_ZERO && cb == CLS_INF);
        if (ca == CLS_NAN || cb == CLS_NAN || inv_c) begin
            cls_c = CLS_NAN;
        end else if (ca == CLS_INF || cb == CLS_INF) begin
            cls_c = CLS_INF;
        end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
            cls_c = CLS_ZERO;
        end else begin
            cls_c = CLS_NORM;
        end
        esum_c = {2'b00, ea} + {2'b00, eb} - BIAS_X;
    end

    // stage 1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_ZERO;
            s1_inv   <= 1'b0;
            s1_exp   <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
            s1_cls   <= cls_c;
            s1_inv   <= inv_c;
            s1_exp   <= esum_c;
            s1_ma    <= {1'b1, fa};
            s1_mb    <= {1'b1, fb};
        end
    end

    assign prod_c = {{SIG_W{1'b0}}, s1_ma} * {{SIG_W{1'b0}}, s1_mb};

    // stage 2 register: significand product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_cls   <= CLS_ZERO;
            s2_inv   <= 1'b0;
            s2_exp   <= '0;
            s2_prod  <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_cls   <= s1_cls;
            s2_inv   <= s1_inv;
            s2_exp   <= s1_exp;
            s2_prod  <= prod_c;
        end
    end

    // bring the leading one to the top bit and adjust the exponent
    always_comb begin
        norm  = s2_prod[PRD_W-1];
        nprod = norm ? s2_prod : {s2_prod[PRD_W-2:0], 1'b0};
        nexp  = s2_exp + {{(EXP_W+1){1'b0}}, norm};
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .prod    (nprod),
        .exp_in  (nexp),
        .sign    (s2_sign),
        .cls     (s2_cls),
        .invalid (s2_inv),
        .res     (rp_res),
        .flags   (rp_flags)
    );

    // output register; holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
            flags     <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            res       <= rp_res;
            flags     <= rp_flags;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed table, latency, backpressure,
// reset and randomized traffic against an arithmetic model.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  trunc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] res;
    logic [3:0]  flags;

    int checks = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    fp_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .trunc     (trunc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // value-level model: exact integer product, then RNE by remainder
    function automatic logic [35:0] ref_mul(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [4:0] k);
        int kk;
        logic [22:0] m;
        logic [22:0] fx, fy;
        int ex, ey, e, msb, sh;
        logic s;
        bit nx, ny, ix, iy, zx, zy;
        longint p, q, rem, half;
        kk = (k > 23) ? 23 : int'(k);
        m = 23'h7FFFFF << kk;
        fx = x[22:0] & m;
        fy = y[22:0] & m;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s = x[31] ^ y[31];
        nx = (ex == 255) && (fx != 0);
        ny = (ey == 255) && (fy != 0);
        ix = (ex == 255) && (fx == 0);
        iy = (ey == 255) && (fy == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny || (ix && zy) || (iy && zx))
            return {32'h7FC00000, ((ix && zy) || (iy && zx)) ? 4'b1000 : 4'b0000};
        if (ix || iy)
            return {s, 8'hFF, 23'h0, 4'b0000};
        if (zx || zy)
            return {s, 31'h0, 4'b0000};
        p = ((longint'(1) << 23) | longint'(fx)) *
            ((longint'(1) << 23) | longint'(fy));
        msb = 0;
        for (int i = 0; i < 64; i++)
            if (p[i]) msb = i;
        sh = msb - 23;
        q = p >> sh;
        rem = p - (q << sh);
        half = longint'(1) << (sh - 1);
        e = ex + ey - 127 + (msb - 46);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0, 4'b0101};
        if (e <= 0)   return {s, 31'h0, 4'b0011};
        return {s, 8'(e), q[22:0], 3'b000, rem != 0};
    endfunction

    // one cycle from a negedge: drive, score the output, log an accept
    task automatic step(input logic v, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [4:0] k,
                        input logic ordy, input logic [35:0] expv,
                        output logic fired);
        in_valid = v;
        a = ia;
        b = ib;
        trunc = k;
        out_ready = ordy;
        #1;
        fired = v && in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {32'h0, res}, 64'h0 - 1);
            end else begin
                chk("sb_res", {32'h0, res}, {32'h0, exp_q[0][35:4]});
                chk("sb_flags", {60'h0, flags}, {60'h0, exp_q[0][3:0]});
                if (ordy) void'(exp_q.pop_front());
            end
        end
        if (fired) exp_q.push_back(expv);
        @(negedge clk);
    endtask

    task automatic drain();
        logic f;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 36'h0, f);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[22:0] = '0;
            3: v[30:23] = 8'($urandom_range(0, 20));
            4: v[30:23] = 8'($urandom_range(230, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  k;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic f;
        int lat, acc, idx, tries;
        logic [31:0] bp_a[5];
        logic [31:0] ra, rb;
        logic [4:0] rk;
        logic rv;

        tbl[0]  = '{32'h3FC00000, 32'h40000000, 5'd0,  32'h40400000, 4'h0};
        tbl[1]  = '{32'h3F800001, 32'h3FC00000, 5'd0,  32'h3FC00002, 4'h1};
        tbl[2]  = '{32'h3F800003, 32'h3FC00000, 5'd0,  32'h3FC00004, 4'h1};
        tbl[3]  = '{32'h7F800000, 32'h00000000, 5'd0,  32'h7FC00000, 4'h8};
        tbl[4]  = '{32'hFF800000, 32'h40000000, 5'd0,  32'hFF800000, 4'h0};
        tbl[5]  = '{32'h00400000, 32'h40000000, 5'd0,  32'h00000000, 4'h0};
        tbl[6]  = '{32'h7F000000, 32'h7F000000, 5'd0,  32'h7F800000, 4'h5};
        tbl[7]  = '{32'h00800000, 32'h00800000, 5'd0,  32'h00000000, 4'h3};
        tbl[8]  = '{32'h3F8007FF, 32'h40000000, 5'd11, 32'h40000000, 4'h0};
        tbl[9]  = '{32'h3F8007FF, 32'h40000000, 5'd0,  32'h400007FF, 4'h0};
        tbl[10] = '{32'h7FC00001, 32'h3F800000, 5'd0,  32'h7FC00000, 4'h0};
        tbl[11] = '{32'h3FFFFFFF, 32'h40400000, 5'd31, 32'h40000000, 4'h0};
        tbl[12] = '{32'hBF800000, 32'h3F800000, 5'd0,  32'hBF800000, 4'h0};
        tbl[13] = '{32'h80000000, 32'h40000000, 5'd0,  32'h80000000, 4'h0};
        tbl[14] = '{32'hFF800000, 32'h7F800001, 5'd0,  32'h7FC00000, 4'h0};
        tbl[15] = '{32'h00000000, 32'hFF800000, 5'd0,  32'h7FC00000, 4'h8};
        tbl[16] = '{32'h3FFFFFFE, 32'h3F800001, 5'd0,  32'h40000000, 4'h1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
        chk("rst_res", {32'h0, res}, 64'd0);
        chk("rst_flags", {60'h0, flags}, 64'd0);
        @(negedge clk);

        // latency through an idle pipeline
        in_valid = 1'b1;
        a = 32'h3FC00000;
        b = 32'h40000000;
        trunc = 5'd0;
        out_ready = 1'b1;
        #1;
        chk("lat_in_ready", {63'h0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd3);
        chk("lat_res", {32'h0, res}, 64'h40400000);
        chk("lat_flags", {60'h0, flags}, 64'd0);
        @(posedge clk);
        @(negedge clk);

        // directed vectors
        foreach (tbl[i]) begin
            f = 1'b0;
            tries = 0;
            while (!f && tries < 20) begin
                step(1'b1, tbl[i].a, tbl[i].b, tbl[i].k, 1'b1,
                     {tbl[i].r, tbl[i].f}, f);
                tries++;
            end
            chk("tbl_accept", {63'h0, f}, 64'd1);
        end
        drain();

        // backpressure: consumer stalled, five back-to-back offers
        bp_a[0] = 32'h3F800000;
        bp_a[1] = 32'h40000000;
        bp_a[2] = 32'h40400000;
        bp_a[3] = 32'h40800000;
        bp_a[4] = 32'h40A00000;
        acc = 0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bp_a[idx], 32'h3FC00000, 5'd0, 1'b0,
                 ref_mul(bp_a[idx], 32'h3FC00000, 5'd0), f);
            if (f) begin
                acc++;
                idx++;
            end
        end
        chk("bp_accepted", 64'(acc), 64'd3);
        chk("bp_in_ready", {63'h0, in_ready}, 64'd0);
        tries = 0;
        while (idx < 5 && tries < 50) begin
            step(1'b1, bp_a[idx], 32'h3FC00000, 5'd0, 1'b1,
                 ref_mul(bp_a[idx], 32'h3FC00000, 5'd0), f);
            if (f) idx++;
            tries++;
        end
        chk("bp_all_sent", 64'(idx), 64'd5);
        drain();

        // reset mid-stream with a stalled, full pipeline
        for (int c = 0; c < 4; c++)
            step(1'b1, 32'h40400000, 32'h40400000, 5'd0, 1'b0,
                 ref_mul(32'h40400000, 32'h40400000, 5'd0), f);
        chk("pre_rst_valid", {63'h0, out_valid}, 64'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", {63'h0, out_valid}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", {63'h0, in_ready}, 64'd1);
        chk("post_rst_res", {32'h0, res}, 64'd0);
        chk("post_rst_flags", {60'h0, flags}, 64'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("no_stale", {63'h0, out_valid}, 64'd0);
            @(negedge clk);
        end

        // randomized traffic with random backpressure
        ra = rand_op();
        rb = rand_op();
        rk = 5'd0;
        for (int n = 0; n < 2000; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            step(rv, ra, rb, rk, ($urandom_range(0, 3) != 0),
                 ref_mul(ra, rb, rk), f);
            if (f) begin
                ra = rand_op();
                rb = rand_op();
                rk = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE-754 floating-point multiplier with a valid/ready stream interface, full special-value handling, round-to-nearest-even, exception flags and a run-time operand-truncation approximation mode. It is the next generation of the combinational multipliers in the approximate-arithmetic library. It serves as the golden/approximate datapath inside clocked accelerator tiles, and as the reference engine in error-characterisation benches.

## Interface
Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
- TW, $clog2(MAN_W+1), width of trunc input

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operand pair this cycle
- a, b  in  W  IEEE operands
- trunc  in  TW  approximation level k (0 = exact), sampled with operands
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- res  out  W  product
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with res

## Operation
- Transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output).
- Approximation: before multiply, zero the lowest min(k,MAN_W) fraction bits of both a and b. The truncated operands are then multiplied exactly. k=0 gives the IEEE-correct result. k is clamped at MAN_W.
- Classification, per operand: exp all-ones & frac≠0 → NaN; exp all-ones & frac=0 → Inf; exp=0 → zero. Subnormals are flushed to zero (FTZ).
- Sign = a.sign ^ b.sign for all non-NaN results.
- Special cases, in priority order:
  - NaN input, or Inf×zero → canonical qNaN {0, all-ones, 1, 0…}. invalid=1 only for Inf×zero.
  - Inf operand → ±Inf.
  - Zero operand → ±0.
- Normal path:
  - Product P of two (MAN_W+1)-bit significands, 2·MAN_W+2 bits.
  - norm = P MSB. If norm=0, left-shift P by 1.
  - Exponent E = ea+eb−BIAS+norm, computed in EXP_W+2-bit signed arithmetic. BIAS = 2^(EXP_W−1)−1.
  - RNE: lsb, guard = next bit, sticky = OR of remaining bits. Round up if guard&(sticky|lsb).
  - Rounding carry-out renormalises: fraction becomes 0, E+1.
  - inexact = guard|sticky.
  - E ≥ 2^EXP_W−1 after rounding → ±Inf, overflow=1, inexact=1.
  - E ≤ 0 → ±0, underflow=1, inexact=1.
- flags are 0 for all special-case results except invalid as stated.

## Timing
- 3-stage pipeline:
  - S1: truncate, classify, exponent sum, sign.
  - S2: significand multiply.
  - S3: normalise, round, pack.
- Latency: 3 cycles from input transfer to out_valid with an idle pipeline and out_ready=1.
- Throughput: 1 result per cycle.
- Global stall: advance = !out_valid || out_ready; in_ready = advance. All stages hold while advance=0.
- Bubbles propagate as cleared stage valids.
- Results leave in input order. No drop or duplication under any out_ready pattern.
- res/flags are stable while out_valid && !out_ready.
- Reset (any time, including mid-operation): all stage valids cleared, out_valid=0, res=0, flags=0, in_ready=1 from the first cycle after release. In-flight operations are discarded.
- in_ready depends combinationally on out_ready (no internal skid buffer).

## Structure
- Package fp_mul_pkg:
  - flag bit indices.
  - Class enum {ZERO, NORM, INF, NAN}.
  - Functions for BIAS, the canonical qNaN pattern and classification, parameterised through EXP_W/MAN_W.
- Sub-module fp_round_pack (S3 combinational core):
  - Inputs: normalised product, E, sign, special class, k-independent.
  - Outputs: res, flags.
  - Reused by future adder/FMA blocks.
- Top level holds the truncation, S1/S2 registers, the valid/stall logic and an S3 output register.

## Test plan
- 0x3FC00000 × 0x40000000, k=0 → res 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
- RNE ties: 0x3F800001 × 0x3FC00000 → 0x3FC00002 (round up, inexact). 0x3F800003 × 0x3FC00000 → 0x3FC00004 (tie to even, inexact).
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
  - 0x00400000 (subnormal) × 0x40000000 → 0x00000000.
- Range: 0x7F000000 × 0x7F000000 → 0x7F800000, overflow|inexact. 0x00800000 × 0x00800000 → 0x00000000, underflow|inexact.
- Approximation: 0x3F8007FF × 0x40000000, k=11 → 0x40000000. Same operands with k=0 → 0x400007FF.
- Backpressure and reset:
  - out_ready=0 with 5 back-to-back inputs → exactly 3 accepted, then in_ready=0. Results emerge in order after out_ready=1.
  - Asserting rst mid-stream → out_valid=0 next cycle. No stale result ever appears.
